// File: rtl/video_out_pkg.sv
// video_out_pkg
// Shared types, default timing constants and helpers for video_out_stage.
//   counter_t     : 9-bit beam/width counter
//   sync_state_e  : composite-sync separator states
//   col7_to_lin8  : 7-bit {SHADOW, C[3:0], LSB, DARK} colour to 8-bit linear
// Build option: VIDEO_OUT_SHADOW_EN enables the DARK/SHADOW arithmetic in
// col7_to_lin8; without it those two bits are ignored.
package video_out_pkg;

  typedef logic [8:0] counter_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOWCNT = 2'd1,
    VSYNC  = 2'd2
  } sync_state_e;

  localparam counter_t H_START_DEF   = 9'd28;
  localparam counter_t H_WIDTH_DEF   = 9'd320;
  localparam counter_t V_START_DEF   = 9'd16;
  localparam counter_t V_HEIGHT_DEF  = 9'd224;
  localparam counter_t BROAD_MIN_DEF = 9'd64;
  localparam counter_t REGEN_LEN     = 9'd29;
  localparam counter_t COUNT_MAX     = 9'd511;

  function automatic counter_t sat_inc(input counter_t c);
    return (c == COUNT_MAX) ? c : c + 9'd1;
  endfunction

  // Replicating the top bits of the 5-bit value into the low bits makes
  // full scale map to 8'hFF and zero to 8'h00.
  function automatic logic [7:0] col7_to_lin8(input logic [6:0] col);
    logic [4:0] v;
    logic [7:0] lin;
`ifndef VIDEO_OUT_SHADOW_EN
    logic       unused_flags;
`endif
    v   = col[5:1];
    lin = {v, v[4:2]};
`ifdef VIDEO_OUT_SHADOW_EN
    if (col[0]) lin = (lin < 8'd8) ? 8'd0 : lin - 8'd8;
    if (col[6]) lin = lin >> 1;
`else
    unused_flags = col[6] | col[0];
`endif
    return lin;
  endfunction

endpackage

// File: rtl/video_out_stage_if.sv
// video_out_stage_if
// Link between the top (colour path, X/Y counters) and csync_sep.
//   ce        : pixel strobe; csync_sep state moves only when ce=1. There is
//               no back-pressure: every ce-qualified sample is consumed.
//   sync_in   : composite sync, active-low, sampled on ce
//   fall      : sync_in falling edge versus previous ce sample (qualify with ce)
//   vsync     : separator currently in VSYNC (drives VSYNC_OUT)
//   vsync_end : ce cycle on which VSYNC is being left
//   hsync     : registered active-high horizontal sync
//   state     : separator state, for debug/observation
interface video_out_stage_if;
  import video_out_pkg::*;

  logic        ce;
  logic        sync_in;
  logic        fall;
  logic        vsync;
  logic        vsync_end;
  logic        hsync;
  sync_state_e state;

  modport master (
    output ce, sync_in,
    input  fall, vsync, vsync_end, hsync, state
  );

  modport slave (
    input  ce, sync_in,
    output fall, vsync, vsync_end, hsync, state
  );
endinterface

// File: rtl/video_out_stage_csync_sep.sv
// csync_sep
// Composite-sync separator: edge detection, low-pulse width counter,
// IDLE/LOWCNT/VSYNC state machine, regenerated HSYNC during vertical sync.
// Ports: clk, rst (async, active-high), sif (video_out_stage_if.slave).
// Parameter BROAD_MIN: low width (pixels) that marks a vertical broad pulse.
module csync_sep
  import video_out_pkg::*;
#(
  parameter counter_t BROAD_MIN = BROAD_MIN_DEF
) (
  input logic              clk,
  input logic              rst,
  video_out_stage_if.slave sif
);

  sync_state_e state_q, state_d;
  counter_t    width_q, width_d;
  counter_t    regen_q, regen_d;
  counter_t    width_inc;
  logic        prev_q;
  logic        hsync_q, hsync_d;
  logic        fall, rise;

  assign fall      = prev_q & ~sif.sync_in;
  assign rise      = ~prev_q & sif.sync_in;
  assign width_inc = sat_inc(width_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      width_q <= '0;
      regen_q <= '0;
      prev_q  <= 1'b1;
      hsync_q <= 1'b0;
    end else if (sif.ce) begin
      state_q <= state_d;
      width_q <= width_d;
      regen_q <= regen_d;
      prev_q  <= sif.sync_in;
      hsync_q <= hsync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    regen_d = regen_q;

    // regen_d counts pixels since the last falling edge (1..REGEN_LEN),
    // 0 once the regenerated pulse is over.
    if (fall) begin
      regen_d = 9'd1;
    end else if (regen_q == REGEN_LEN) begin
      regen_d = '0;
    end else if (regen_q != '0) begin
      regen_d = regen_q + 9'd1;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = LOWCNT;
          width_d = 9'd1;
        end
      end
      LOWCNT: begin
        if (rise) begin
          state_d = IDLE;
        end else begin
          width_d = width_inc;
          if (width_inc >= BROAD_MIN) state_d = VSYNC;
        end
      end
      VSYNC: begin
        // A new pulse restarts the width count without leaving VSYNC; only
        // a short (equalising/line) pulse ends vertical sync.
        if (fall) begin
          width_d = 9'd1;
        end else if (rise) begin
          if (width_q < BROAD_MIN) state_d = IDLE;
        end else if (!sif.sync_in) begin
          width_d = width_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    hsync_d = (state_d == VSYNC) ? (regen_d != '0) : ~sif.sync_in;
  end

  assign sif.fall      = fall;
  assign sif.vsync     = (state_q == VSYNC);
  assign sif.vsync_end = sif.ce & (state_q == VSYNC) & (state_d != VSYNC);
  assign sif.hsync     = hsync_q;
  assign sif.state     = state_q;

endmodule

// File: rtl/video_out_stage.sv
// video_out_stage
// Pixel-rate back end: 7-bit colour to 8-bit linear RGB, sync separation,
// beam counters and active-window flag. All state moves on VIDEO_CE only;
// outputs are registered on the CE edge of the sample they describe.
// Ports: CLK_24M, RESET (async, active-high), VIDEO_CE, VIDEO_R/G/B (7b),
//   VIDEO_SYNC (active-low) in; R8/G8/B8, HSYNC_OUT, VSYNC_OUT, DE,
//   PIX_X, PIX_Y, LINE_LEN out.
// Build option: VIDEO_OUT_SHADOW_EN enables DARK/SHADOW colour arithmetic.
module video_out_stage
  import video_out_pkg::*;
#(
  parameter counter_t H_START   = H_START_DEF,
  parameter counter_t H_WIDTH   = H_WIDTH_DEF,
  parameter counter_t V_START   = V_START_DEF,
  parameter counter_t V_HEIGHT  = V_HEIGHT_DEF,
  parameter counter_t BROAD_MIN = BROAD_MIN_DEF
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       VIDEO_CE,
  input  logic [6:0] VIDEO_R,
  input  logic [6:0] VIDEO_G,
  input  logic [6:0] VIDEO_B,
  input  logic       VIDEO_SYNC,
  output logic [7:0] R8,
  output logic [7:0] G8,
  output logic [7:0] B8,
  output logic       HSYNC_OUT,
  output logic       VSYNC_OUT,
  output logic       DE,
  output logic [8:0] PIX_X,
  output logic [8:0] PIX_Y,
  output logic [8:0] LINE_LEN
);

  video_out_stage_if sif ();

  assign sif.ce      = VIDEO_CE;
  assign sif.sync_in = VIDEO_SYNC;

  csync_sep #(
    .BROAD_MIN (BROAD_MIN)
  ) u_csync_sep (
    .clk (CLK_24M),
    .rst (RESET),
    .sif (sif)
  );

  sync_state_e unused_state;
  assign unused_state = sif.state;

  counter_t x_q, x_d;
  counter_t y_q, y_d;
  counter_t x_off, y_off;
  logic     line_seen_q;
  logic     de_d;

  always_comb begin
    x_d = sif.fall ? '0 : sat_inc(x_q);
    y_d = y_q;
    if (sif.vsync_end) begin
      y_d = '0;
    end else if (sif.fall && !sif.vsync) begin
      y_d = sat_inc(y_q);
    end
  end

  // Unsigned wrap makes positions before the window start fail the compare.
  assign x_off = x_d - H_START;
  assign y_off = y_d - V_START;
  assign de_d  = (x_off < H_WIDTH) && (y_off < V_HEIGHT);

  assign VSYNC_OUT = sif.vsync;
  assign HSYNC_OUT = sif.hsync;

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      x_q         <= '0;
      y_q         <= '0;
      line_seen_q <= 1'b0;
      LINE_LEN    <= '0;
      DE          <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      R8          <= '0;
      G8          <= '0;
      B8          <= '0;
    end else if (VIDEO_CE) begin
      x_q <= x_d;
      y_q <= y_d;
      // The first edge after reset only starts a line; the count up to it
      // is not a complete line, so it is not reported.
      if (sif.fall) begin
        line_seen_q <= 1'b1;
        if (line_seen_q) LINE_LEN <= sat_inc(x_q);
      end
      DE    <= de_d;
      PIX_X <= de_d ? x_off : '0;
      PIX_Y <= de_d ? y_off : '0;
      R8    <= de_d ? col7_to_lin8(VIDEO_R) : 8'd0;
      G8    <= de_d ? col7_to_lin8(VIDEO_G) : 8'd0;
      B8    <= de_d ? col7_to_lin8(VIDEO_B) : 8'd0;
    end
  end

endmodule

// File: tb/tb_video_out_stage.sv
// tb_video_out_stage
// Randomized scoreboard bench for video_out_stage. A pixel-level reference
// model (low-run lengths, pixel positions, plain arithmetic colour) pushes
// one expected output word per strobe; a monitor pops and compares after
// every strobe and checks that outputs hold between strobes.
// Reduced window sizes keep frames short; honours VIDEO_OUT_SHADOW_EN.
module tb_video_out_stage;

  localparam int H_START   = 28;
  localparam int H_WIDTH   = 20;
  localparam int V_START   = 4;
  localparam int V_HEIGHT  = 6;
  localparam int BROAD_MIN = 64;
  localparam int REGEN     = 29;
  localparam int W         = 54;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       ce = 1'b0;
  logic       sync = 1'b1;
  logic [6:0] vr = '0, vg = '0, vb = '0;
  logic [7:0] r8, g8, b8;
  logic       hs_out, vs_out, de;
  logic [8:0] pix_x, pix_y, line_len;

  video_out_stage #(
    .H_START   (9'd28),
    .H_WIDTH   (9'd20),
    .V_START   (9'd4),
    .V_HEIGHT  (9'd6),
    .BROAD_MIN (9'd64)
  ) dut (
    .CLK_24M    (clk),
    .RESET      (rst),
    .VIDEO_CE   (ce),
    .VIDEO_R    (vr),
    .VIDEO_G    (vg),
    .VIDEO_B    (vb),
    .VIDEO_SYNC (sync),
    .R8         (r8),
    .G8         (g8),
    .B8         (b8),
    .HSYNC_OUT  (hs_out),
    .VSYNC_OUT  (vs_out),
    .DE         (de),
    .PIX_X      (pix_x),
    .PIX_Y      (pix_y),
    .LINE_LEN   (line_len)
  );

  wire [W-1:0] got_v = {r8, g8, b8, hs_out, vs_out, de, pix_x, pix_y, line_len};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  bit           have_last = 1'b0;
  int           checks = 0;
  int           errors = 0;

  logic [6:0] dir_col [4] = '{7'b0111110, 7'b0111111, 7'b1111110, 7'b1000001};
`ifdef VIDEO_OUT_SHADOW_EN
  logic [7:0] dir_exp [4] = '{8'hFF, 8'hF7, 8'h7F, 8'h00};
`else
  logic [7:0] dir_exp [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
`endif

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("r=%h g=%h b=%h hs=%b vs=%b de=%b px=%0d py=%0d ll=%0d",
                     v[53:46], v[45:38], v[37:30], v[29], v[28], v[27],
                     v[26:18], v[17:9], v[8:0]);
  endfunction

  task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %s required %s", name, $time, fmt(got), fmt(e));
    end
  endtask

  task automatic check_zero(input string name);
    compare(name, got_v, '0);
  endtask

  // reference model
  bit m_prev, m_in_vs, m_seen;
  int m_low_run, m_since_fall, m_x, m_y, m_ll;

  task automatic model_reset();
    m_prev = 1'b1; m_in_vs = 1'b0; m_seen = 1'b0;
    m_low_run = 0; m_since_fall = 0; m_x = 0; m_y = 0; m_ll = 0;
  endtask

  function automatic logic [7:0] ref_lin(input logic [6:0] c);
    int v, lin;
    v   = int'(c[5:1]);
    lin = v * 8 + v / 4;
`ifdef VIDEO_OUT_SHADOW_EN
    if (c[0]) lin = (lin >= 8) ? lin - 8 : 0;
    if (c[6]) lin = lin / 2;
`endif
    return lin[7:0];
  endfunction

  task automatic model_step(input bit s, input logic [6:0] cr, input logic [6:0] cg,
                            input logic [6:0] cb, output logic [W-1:0] e);
    bit fall, rise, was_vs, vs_end, hs, d;
    logic [7:0] re, ge, be;
    logic [8:0] px, py, ll;
    fall   = m_prev && !s;
    rise   = !m_prev && s;
    was_vs = m_in_vs;
    vs_end = 1'b0;
    if (fall) m_low_run = 1;
    else if (!s) m_low_run++;
    if (fall) m_since_fall = 1;
    else if (m_since_fall > 0 && m_since_fall < 1000) m_since_fall++;
    if (m_in_vs && rise && m_low_run < BROAD_MIN) begin
      m_in_vs = 1'b0;
      vs_end  = 1'b1;
    end else if (!m_in_vs && !s && m_low_run >= BROAD_MIN) begin
      m_in_vs = 1'b1;
    end
    hs = m_in_vs ? (m_since_fall >= 1 && m_since_fall <= REGEN) : !s;
    if (fall) begin
      if (m_seen) m_ll = (m_x + 1 > 511) ? 511 : m_x + 1;
      m_seen = 1'b1;
      m_x = 0;
    end else begin
      m_x = (m_x >= 511) ? 511 : m_x + 1;
    end
    if (vs_end) m_y = 0;
    else if (fall && !was_vs) m_y = (m_y >= 511) ? 511 : m_y + 1;
    d = (m_x >= H_START) && (m_x < H_START + H_WIDTH) &&
        (m_y >= V_START) && (m_y < V_START + V_HEIGHT);
    px = d ? 9'(m_x - H_START) : 9'd0;
    py = d ? 9'(m_y - V_START) : 9'd0;
    ll = 9'(m_ll);
    re = d ? ref_lin(cr) : 8'd0;
    ge = d ? ref_lin(cg) : 8'd0;
    be = d ? ref_lin(cb) : 8'd0;
    m_prev = s;
    e = {re, ge, be, hs, m_in_vs, d, px, py, ll};
  endtask

  // driver tasks: one pixel = one CE cycle followed by three idle cycles
  task automatic drive_pixel(input bit s, input logic [6:0] cr, input logic [6:0] cg,
                             input logic [6:0] cb, input bit push, input bit dir,
                             input logic [7:0] dir_val);
    logic [W-1:0] e;
    @(negedge clk);
    ce = 1'b1; sync = s; vr = cr; vg = cg; vb = cb;
    if (push) begin
      model_step(s, cr, cg, cb, e);
      if (dir && e[27]) e[53:30] = {dir_val, dir_val, dir_val};
      exp_q.push_back(e);
    end
    @(negedge clk);
    ce = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_rand_pixel(input bit s);
    drive_pixel(s, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                7'($urandom_range(0, 127)), 1'b1, 1'b0, 8'd0);
  endtask

  task automatic drive_line(input int len, input int low, input bit directed);
    for (int i = 0; i < len; i++) begin
      if (directed && i >= H_START && i < H_START + 4)
        drive_pixel(i >= low, dir_col[i - H_START], dir_col[i - H_START],
                    dir_col[i - H_START], 1'b1, 1'b1, dir_exp[i - H_START]);
      else
        drive_rand_pixel(i >= low);
    end
  endtask

  task automatic drive_frame(input int b0, input int b1, input int b2,
                             input int short_w, input int dir_line);
    drive_line(b0 + 40, b0, 1'b0);
    drive_line(b1 + 40, b1, 1'b0);
    drive_line(b2 + 40, b2, 1'b0);
    drive_line(64, short_w, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k == 10) drive_line(90, BROAD_MIN - 1, 1'b0);
      else drive_line($urandom_range(50, 80), $urandom_range(20, 40), k == dir_line);
    end
  endtask

  // monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (ce) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow at %0t: got %s required queued entry", $time, fmt(got_v));
        end else begin
          last_exp = exp_q.pop_front();
          compare("pixel", got_v, last_exp);
          have_last = 1'b1;
        end
      end else if (have_last) begin
        #1;
        compare("hold", got_v, last_exp);
      end
    end
  end

  // watchdog
  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    model_reset();
    repeat (4) begin
      drive_pixel(1'b1, 7'h7f, 7'h7f, 7'h7f, 1'b0, 1'b0, 8'd0);
      check_zero("reset_hold");
    end
    @(negedge clk);
    rst = 1'b0;

    repeat (5) drive_rand_pixel(1'b1);
    repeat (3) drive_line(384, REGEN, 1'b0);

    drive_frame(160, 160, 160, REGEN, 5);
    drive_frame(BROAD_MIN, BROAD_MIN, BROAD_MIN + 1, BROAD_MIN - 1, -1);
    drive_frame($urandom_range(64, 170), $urandom_range(64, 170),
                $urandom_range(64, 170), $urandom_range(20, 63), 4);

    // mid-line reset at X=200
    for (int i = 0; i <= 200; i++) drive_rand_pixel(i >= REGEN);
    @(posedge clk);
    #3;
    have_last = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("reset_mid");
    model_reset();
    repeat (3) begin
      drive_pixel(1'b1, 7'h7f, 7'h7f, 7'h7f, 1'b0, 1'b0, 8'd0);
      check_zero("reset_mid_hold");
    end
    @(negedge clk);
    rst = 1'b0;

    repeat (50) drive_rand_pixel(1'b1);
    drive_frame(160, 160, 160, REGEN, 3);
    drive_frame($urandom_range(64, 170), $urandom_range(64, 170),
                $urandom_range(64, 170), $urandom_range(20, 63), 8);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
